// File: rtl/qr_row_feeder_if.sv
// ---------------------------------------------------------------------------
// qr_row_feeder_if
// Bundles the element input handshake and the packed-row output stream of
// qr_row_feeder.
//   in_data  : element a(r,c), signed fixed point, row-major order
//   in_valid : in_data valid
//   in_ready : feeder has a free write bank (handshake = in_valid & in_ready)
//   a_ij_o   : packed row, column 0 in the most significant slice
//   valid_o  : row valid (contiguous burst of NUM_ROWS rows)
//   frame_o  : one-cycle marker on the first row of each burst
// Modports:
//   master : the environment (element source and row consumer)
//   slave  : the feeder itself
// ---------------------------------------------------------------------------
interface qr_row_feeder_if #(
    parameter int DATA_WIDTH = 20,
    parameter int D_WIDTH    = 4
);
    logic [DATA_WIDTH-1:0]         in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_WIDTH*D_WIDTH-1:0] a_ij_o;
    logic                          valid_o;
    logic                          frame_o;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  a_ij_o,
        input  valid_o,
        input  frame_o
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output a_ij_o,
        output valid_o,
        output frame_o
    );
endinterface

// File: rtl/qr_row_feeder.sv
// ---------------------------------------------------------------------------
// qr_row_feeder
// Collects matrix elements one at a time (row-major), assembles a
// NUM_ROWS x D_WIDTH matrix in one half of a ping-pong buffer, then streams
// it to QR_CORDIC one packed row per cycle, last row first, as an unbroken
// valid burst. The other half keeps accepting the next matrix meanwhile.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous clear of both banks, counters and the read FSM
//   bus    : qr_row_feeder_if.slave (element handshake + row stream)
// ---------------------------------------------------------------------------
module qr_row_feeder #(
    parameter int DATA_WIDTH = 20,
    parameter int D_WIDTH    = 4,
    parameter int NUM_ROWS   = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    qr_row_feeder_if.slave bus
);
    localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int COL_W  = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
    localparam int ADDR_W = $clog2(2 * NUM_ROWS);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(D_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP
    } state_t;

    // Bank b occupies RAM words b*NUM_ROWS .. b*NUM_ROWS+NUM_ROWS-1.
    function automatic logic [ADDR_W-1:0] bank_addr(input logic bank,
                                                     input logic [ROW_W-1:0] row);
        bank_addr = bank ? (ADDR_W'(NUM_ROWS) + ADDR_W'(row)) : ADDR_W'(row);
    endfunction

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic             wr_bank_reg;
    logic [ROW_W-1:0] wr_row_reg;
    logic [COL_W-1:0] wr_col_reg;
    logic [1:0]       full_reg;
    logic [1:0]       full_next;
    logic             in_ready_w;
    logic             accept;
    logic             wr_done;
    logic [ADDR_W-1:0] wr_addr;

    assign in_ready_w   = ~full_reg[wr_bank_reg];
    assign bus.in_ready = in_ready_w;
    // flush wins over a handshake presented in the same cycle
    assign accept  = bus.in_valid & in_ready_w & ~flush;
    assign wr_done = accept && (wr_row_reg == LAST_ROW) && (wr_col_reg == LAST_COL);
    assign wr_addr = bank_addr(wr_bank_reg, wr_row_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_reg <= 1'b0;
            wr_row_reg  <= '0;
            wr_col_reg  <= '0;
        end else if (flush) begin
            wr_bank_reg <= 1'b0;
            wr_row_reg  <= '0;
            wr_col_reg  <= '0;
        end else if (accept) begin
            if (wr_col_reg == LAST_COL) begin
                wr_col_reg <= '0;
                wr_row_reg <= (wr_row_reg == LAST_ROW) ? '0 : wr_row_reg + ROW_W'(1);
            end else begin
                wr_col_reg <= wr_col_reg + COL_W'(1);
            end
            if (wr_done) begin
                wr_bank_reg <= ~wr_bank_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [ROW_W-1:0] rd_row_reg, rd_row_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic             rd_bank_reg, rd_bank_next;
    logic             valid_reg, valid_next;
    logic             frame_reg, frame_next;
    logic             rd_free;
    logic [ADDR_W-1:0] rd_addr;

    // A filling bank and the bank being released are always different, so
    // both updates can land in the same cycle without interfering.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_full
            assign full_next[gi] =
                (full_reg[gi] & ~(rd_free & (rd_bank_reg == 1'(gi)))) |
                (wr_done & (wr_bank_reg == 1'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= '0;
        end else if (flush) begin
            full_reg <= '0;
        end else begin
            full_reg <= full_next;
        end
    end

    // The RAM address is chosen one cycle ahead so that the registered read
    // lines up with valid_reg.
    always_comb begin
        state_next   = state_reg;
        rd_row_next  = rd_row_reg;
        gap_cnt_next = gap_cnt_reg;
        rd_bank_next = rd_bank_reg;
        valid_next   = 1'b0;
        frame_next   = 1'b0;
        rd_free      = 1'b0;
        rd_addr      = bank_addr(rd_bank_reg, LAST_ROW);

        case (state_reg)
            IDLE: begin
                if (full_reg[rd_bank_reg]) begin
                    state_next  = STREAM;
                    rd_row_next = LAST_ROW;
                    valid_next  = 1'b1;
                    frame_next  = 1'b1;
                end
            end
            STREAM: begin
                if (rd_row_reg == '0) begin
                    rd_free      = 1'b1;
                    rd_bank_next = ~rd_bank_reg;
                    state_next   = GAP;
                    gap_cnt_next = GAP_W'(GAP_CYCLES - 1);
                end else begin
                    rd_row_next = rd_row_reg - ROW_W'(1);
                    valid_next  = 1'b1;
                    rd_addr     = bank_addr(rd_bank_reg, rd_row_reg - ROW_W'(1));
                end
            end
            GAP: begin
                if (gap_cnt_reg == '0) begin
                    // Go straight back into a burst if the other bank is ready.
                    if (full_reg[rd_bank_reg]) begin
                        state_next  = STREAM;
                        rd_row_next = LAST_ROW;
                        valid_next  = 1'b1;
                        frame_next  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rd_row_reg  <= '0;
            gap_cnt_reg <= '0;
            rd_bank_reg <= 1'b0;
            valid_reg   <= 1'b0;
            frame_reg   <= 1'b0;
        end else if (flush) begin
            state_reg   <= IDLE;
            rd_row_reg  <= '0;
            gap_cnt_reg <= '0;
            rd_bank_reg <= 1'b0;
            valid_reg   <= 1'b0;
            frame_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rd_row_reg  <= rd_row_next;
            gap_cnt_reg <= gap_cnt_next;
            rd_bank_reg <= rd_bank_next;
            valid_reg   <= valid_next;
            frame_reg   <= frame_next;
        end
    end

    // ------------------------------------------------------------------
    // Storage: one RAM per column so a single element can be written while
    // a full packed row is read in one cycle.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH*D_WIDTH-1:0] rd_row_data;

    generate
        for (gi = 0; gi < D_WIDTH; gi++) begin : g_col
            logic [DATA_WIDTH-1:0] col_mem [0:2*NUM_ROWS-1];
            logic [DATA_WIDTH-1:0] col_rd_reg;

            always_ff @(posedge clk) begin
                if (accept && (wr_col_reg == COL_W'(gi))) begin
                    col_mem[wr_addr] <= bus.in_data;
                end
                col_rd_reg <= col_mem[rd_addr];
            end

            // Column 0 lands in the most significant slice.
            assign rd_row_data[(D_WIDTH-gi)*DATA_WIDTH-1 -: DATA_WIDTH] = col_rd_reg;
        end
    endgenerate

    // The RAM output register has no reset; gating with valid keeps the bus
    // at zero between bursts and immediately after reset or flush.
    assign bus.a_ij_o  = valid_reg ? rd_row_data : '0;
    assign bus.valid_o = valid_reg;
    assign bus.frame_o = frame_reg;

endmodule

// File: tb/tb_qr_row_feeder.sv
// ---------------------------------------------------------------------------
// tb_qr_row_feeder
// Scoreboard bench for qr_row_feeder: every completed input matrix pushes its
// expected rows (last row first) into a queue, and a monitor pops and compares
// each valid row as the feeder emits it.
// ---------------------------------------------------------------------------
module tb_qr_row_feeder;
    localparam int W   = 20;
    localparam int D   = 4;
    localparam int R   = 8;
    localparam int GAP = 1;

    typedef struct {
        logic [W*D-1:0] data;
        logic           frame;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;

    qr_row_feeder_if #(.DATA_WIDTH(W), .D_WIDTH(D)) bus ();

    qr_row_feeder #(
        .DATA_WIDTH(W),
        .D_WIDTH   (D),
        .NUM_ROWS  (R),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus)
    );

    int             n_checks;
    int             n_fail;
    int             cyc;
    int             exp_frame_cyc;
    int             run_len;
    int             gap_len;
    int             n_bursts;
    bit             abort_flag;
    exp_t           exp_q[$];
    exp_t           mon_e;
    logic [W*D-1:0] first_word;
    logic [W*D-1:0] last_word;
    logic [W-1:0]   mat [0:R-1][0:D-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [W*D-1:0] got,
                            input logic [W*D-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: compares every emitted row against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.valid_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("row_expected", 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("row_data", bus.a_ij_o, mon_e.data);
                    check_eq("row_frame", bus.frame_o, mon_e.frame);
                    $display("row cyc=%0d data=%h frame=%0b", cyc, bus.a_ij_o, bus.frame_o);
                end
                if (bus.frame_o) begin
                    check_eq("first_row_latency", cyc, exp_frame_cyc);
                    check_eq("gap_before_burst", (gap_len >= GAP), 1);
                    first_word = bus.a_ij_o;
                end
                last_word = bus.a_ij_o;
                run_len++;
                gap_len = 0;
            end else begin
                check_eq("idle_data_zero", bus.a_ij_o, 0);
                check_eq("idle_frame_zero", bus.frame_o, 0);
                if (run_len != 0) begin
                    if (!abort_flag) begin
                        check_eq("burst_len", run_len, R);
                        n_bursts++;
                    end
                    abort_flag = 1'b0;
                    run_len = 0;
                end
                gap_len++;
            end
        end
    end

    // Present one element; decide acceptance from in_ready at the negedge
    // preceding the capturing edge.
    task automatic send_elem(input logic [W-1:0] d, input bit last);
        bit accepted;
        accepted = 1'b0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 200 && !accepted; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted = 1'b1;
                if (last) exp_frame_cyc = cyc + 2;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) check_eq("in_ready_timeout", 0, 1);
    endtask

    // mode 0: (4r+c+1)<<10, mode 1: random, mode 2: negative patterns
    task automatic send_matrix(input int mode, input bit gaps);
        exp_t e;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < D; c++) begin
                case (mode)
                    0:       mat[r][c] = W'((4 * r + c + 1) << 10);
                    1:       mat[r][c] = W'($urandom);
                    default: begin
                        case (c)
                            0:       mat[r][c] = 20'h80000;
                            1:       mat[r][c] = 20'hFFC00;
                            2:       mat[r][c] = W'(-((r + 1) << 10));
                            default: mat[r][c] = 20'h80000 | W'(r);
                        endcase
                    end
                endcase
            end
        end
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < D; c++) begin
                if (gaps && ($urandom_range(1) == 1)) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                send_elem(mat[r][c], (r == R - 1) && (c == D - 1));
            end
        end
        for (int r = R - 1; r >= 0; r--) begin
            e.data  = {mat[r][0], mat[r][1], mat[r][2], mat[r][3]};
            e.frame = (r == R - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.valid_o) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_eq("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.frame_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("frame_seen", bus.frame_o, 1);
    endtask

    initial begin
        int b0;
        int vcount;
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        exp_frame_cyc = -1;
        run_len = 0;
        gap_len = 100;
        n_bursts = 0;
        abort_flag = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("reset_valid", bus.valid_o, 0);
        check_eq("reset_frame", bus.frame_o, 0);
        check_eq("reset_data", bus.a_ij_o, 0);
        check_eq("reset_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // 1: ramp matrix
        send_matrix(0, 1'b0);
        wait_drain();
        check_eq("t1_first_word", first_word, 80'h07400_07800_07C00_08000);
        check_eq("t1_last_word", last_word, 80'h00400_00800_00C00_01000);

        // 2: three matrices streamed back to back
        b0 = n_bursts;
        send_matrix(1, 1'b0);
        send_matrix(1, 1'b0);
        send_matrix(1, 1'b0);
        wait_drain();
        check_eq("t2_burst_count", n_bursts - b0, 3);

        // 3: negative values
        send_matrix(2, 1'b0);
        wait_drain();

        // 4: random input gaps
        send_matrix(1, 1'b1);
        send_matrix(2, 1'b1);
        wait_drain();

        // 5a: flush mid-burst
        send_matrix(1, 1'b0);
        wait_frame();
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        abort_flag = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_eq("t5_flush_valid", bus.valid_o, 0);
        check_eq("t5_flush_data", bus.a_ij_o, 0);
        check_eq("t5_flush_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        send_matrix(0, 1'b0);
        wait_drain();

        // 5b: asynchronous reset mid-burst
        send_matrix(1, 1'b0);
        wait_frame();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        abort_flag = 1'b1;
        #1;
        check_eq("t5_rst_valid", bus.valid_o, 0);
        check_eq("t5_rst_data", bus.a_ij_o, 0);
        check_eq("t5_rst_frame", bus.frame_o, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("t5_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        send_matrix(2, 1'b0);
        wait_drain();

        // 6: partial matrix never streams, then is discarded by flush
        for (int i = 0; i < 17; i++) begin
            send_elem(W'((i + 1) << 4), 1'b0);
        end
        vcount = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.valid_o) vcount++;
        end
        check_eq("t6_no_valid", vcount, 0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        send_matrix(0, 1'b0);
        wait_drain();
        check_eq("t6_after_flush_first", first_word, 80'h07400_07800_07C00_08000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
